// File: rtl/timer_interrupt_controller.sv
// Timer interrupt controller: masks TIFR with TIMSK and the SREG I-bit, arbitrates by vector priority, and drives the CPU request.
// Latency: a flag visible before edge k gives irq_req after edge k+1; clear pulse one cycle after ack, then HOLDOFF_CYCLES idle.
// Backpressure: a request is held until irq_ack or withdrawal. Build option TIMER_IRQ_COUNT_EN adds the serviced counter and last_vector.
module timer_interrupt_controller #(
    parameter logic [15:0] VECTOR_BASE    = 16'h0000,
    parameter int          HOLDOFF_CYCLES = 1
) (
    input  logic        sysClock,
    input  logic        rst_n,
    input  logic [7:0]  TIFR_in,
    input  logic [7:0]  TIMSK_in,
    input  logic        global_int_enable,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    output logic [7:0]  TIFR_clear_mask,
    output logic        irq_pending
`ifdef TIMER_IRQ_COUNT_EN
    ,
    output logic [15:0] irq_serviced_count,
    output logic [15:0] last_vector
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CLEAR   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    // Holdoff counter is loaded with N-1 so that HOLDOFF lasts exactly N cycles.
    localparam logic [1:0] HOLD_LOAD = 2'(HOLDOFF_CYCLES - 1);

    state_t      state;
    logic [7:0]  tifr_q;
    logic [7:0]  timsk_q;
    logic [7:0]  pending_vec;
    logic [2:0]  win_bit;
    logic [15:0] win_offset;
    logic [15:0] win_vector;
    logic [2:0]  lat_bit;
    logic [1:0]  hold_cnt;
    logic        withdraw;
    logic        accept;

    assign pending_vec = tifr_q & timsk_q;
    assign win_vector  = VECTOR_BASE + win_offset;
    assign withdraw    = !global_int_enable || !pending_vec[lat_bit];
    assign accept      = (state == REQ) && irq_ack;

    // Register the flag and mask inputs; irq_pending ignores the I-bit.
    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            tifr_q      <= 8'h00;
            timsk_q     <= 8'h00;
            irq_pending <= 1'b0;
        end else begin
            tifr_q      <= TIFR_in;
            timsk_q     <= TIMSK_in;
            irq_pending <= |pending_vec;
        end
    end

    // Fixed priority: bit 7 (OCF2) highest down to bit 0 (TOV0).
    always_comb begin
        win_bit    = 3'd0;
        win_offset = 16'h0016;
        casez (pending_vec)
            8'b1???????: begin win_bit = 3'd7; win_offset = 16'h0008; end
            8'b01??????: begin win_bit = 3'd6; win_offset = 16'h000A; end
            8'b001?????: begin win_bit = 3'd5; win_offset = 16'h000C; end
            8'b0001????: begin win_bit = 3'd4; win_offset = 16'h000E; end
            8'b00001???: begin win_bit = 3'd3; win_offset = 16'h0010; end
            8'b000001??: begin win_bit = 3'd2; win_offset = 16'h0012; end
            8'b0000001?: begin win_bit = 3'd1; win_offset = 16'h0014; end
            default:     begin win_bit = 3'd0; win_offset = 16'h0016; end
        endcase
    end

    // Request/acknowledge sequencer with registered outputs.
    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            irq_req         <= 1'b0;
            irq_vector      <= VECTOR_BASE;
            TIFR_clear_mask <= 8'h00;
            lat_bit         <= 3'd0;
            hold_cnt        <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    TIFR_clear_mask <= 8'h00;
                    if ((|pending_vec) && global_int_enable) begin
                        lat_bit    <= win_bit;
                        irq_vector <= win_vector;
                        irq_req    <= 1'b1;
                        state      <= REQ;
                    end else begin
                        irq_req <= 1'b0;
                    end
                end
                REQ: begin
                    // Ack wins over a same-cycle withdraw; later higher-priority flags wait.
                    if (irq_ack) begin
                        irq_req         <= 1'b0;
                        TIFR_clear_mask <= 8'h01 << lat_bit;
                        state           <= CLEAR;
                    end else if (withdraw) begin
                        irq_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                CLEAR: begin
                    TIFR_clear_mask <= 8'h00;
                    hold_cnt        <= HOLD_LOAD;
                    state           <= HOLDOFF;
                end
                HOLDOFF: begin
                    // Give the cleared TIFR time to come back through the input stage.
                    if (hold_cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 2'd1;
                    end
                end
                default: begin
                    irq_req         <= 1'b0;
                    TIFR_clear_mask <= 8'h00;
                    state           <= IDLE;
                end
            endcase
        end
    end

`ifdef TIMER_IRQ_COUNT_EN
    // Count acknowledged interrupts (saturating) and remember the last vector taken.
    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            irq_serviced_count <= 16'h0000;
            last_vector        <= VECTOR_BASE;
        end else if (accept) begin
            if (irq_serviced_count != 16'hFFFF) begin
                irq_serviced_count <= irq_serviced_count + 16'h0001;
            end
            last_vector <= irq_vector;
        end
    end
`else
    // Without the counter option the acceptance strobe has no consumer.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_timer_interrupt_controller.sv
// Bench for timer_interrupt_controller: directed scenarios plus randomized flag/mask/I-bit/ack traffic.
// A behavioural model (pending = flags & mask one cycle late, busy window after each ack) predicts every output.
// The bench acts as the TIFR block: it clears the pulsed bit on the edge that ends the clear pulse.
module tb_timer_interrupt_controller;

    localparam logic [15:0] VB   = 16'h0000;
    localparam int          HOLD = 1;

    logic        sysClock = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  tifr     = 8'h00;
    logic [7:0]  timsk    = 8'h00;
    logic        ien      = 1'b0;
    logic        ack      = 1'b0;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic [7:0]  TIFR_clear_mask;
    logic        irq_pending;
`ifdef TIMER_IRQ_COUNT_EN
    logic [15:0] irq_serviced_count;
    logic [15:0] last_vector;
`endif

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         pulse_cnt = 0;
    int         p0;
    logic [7:0] seen_mask = 8'h00;

    // Reference model state
    logic [7:0]  m_tifr_q, m_timsk_q, m_mask;
    logic        m_pend, m_req;
    logic [15:0] m_vec, m_last;
    int          m_bit, m_wait, m_count;

    timer_interrupt_controller #(
        .VECTOR_BASE    (VB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .sysClock          (sysClock),
        .rst_n             (rst_n),
        .TIFR_in           (tifr),
        .TIMSK_in          (timsk),
        .global_int_enable (ien),
        .irq_ack           (ack),
        .irq_req           (irq_req),
        .irq_vector        (irq_vector),
        .TIFR_clear_mask   (TIFR_clear_mask),
        .irq_pending       (irq_pending)
`ifdef TIMER_IRQ_COUNT_EN
        ,
        .irq_serviced_count(irq_serviced_count),
        .last_vector       (last_vector)
`endif
    );

    always #5 sysClock = ~sysClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tifr_q  = 8'h00;
        m_timsk_q = 8'h00;
        m_mask    = 8'h00;
        m_pend    = 1'b0;
        m_req     = 1'b0;
        m_vec     = VB;
        m_last    = VB;
        m_bit     = 0;
        m_wait    = 0;
        m_count   = 0;
    endtask

    // One clock edge of the reference model, using the inputs present before the edge.
    task automatic model_step();
        logic [7:0] pend_now;
        int hb;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pend_now = m_tifr_q & m_timsk_q;
        m_mask   = 8'h00;
        if (m_req) begin
            if (ack) begin
                m_req  = 1'b0;
                m_mask = 8'(1 << m_bit);
                m_wait = 1 + HOLD;        // one clear cycle plus the holdoff
                if (m_count < 65535) m_count++;
                m_last = m_vec;
            end else if (!ien || !pend_now[m_bit]) begin
                m_req = 1'b0;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (ien && pend_now != 8'h00) begin
            hb = 0;
            for (int b = 0; b < 8; b++) if (pend_now[b]) hb = b;
            m_bit = hb;
            m_req = 1'b1;
            m_vec = VB + 16'd8 + 16'(2 * (7 - hb));
        end
        m_pend    = |pend_now;
        m_tifr_q  = tifr;
        m_timsk_q = timsk;
    endtask

    task automatic tick();
        @(posedge sysClock);
        model_step();
        #1;
        ack = 1'b0;
        if (rst_n) tifr = tifr & ~seen_mask;
        @(negedge sysClock);
        chk("irq_req",     32'(irq_req),         32'(m_req));
        chk("irq_vector",  32'(irq_vector),      32'(m_vec));
        chk("clear_mask",  32'(TIFR_clear_mask), 32'(m_mask));
        chk("irq_pending", 32'(irq_pending),     32'(m_pend));
`ifdef TIMER_IRQ_COUNT_EN
        chk("serviced_count", 32'(irq_serviced_count), 32'(m_count));
        chk("last_vector",    32'(last_vector),        32'(m_last));
`endif
        seen_mask = TIFR_clear_mask;
        if (TIFR_clear_mask != 8'h00) pulse_cnt++;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !irq_req; i++) tick();
        chk(tag, 32'(irq_req), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tifr  = 8'h00;
        timsk = 8'h00;
        ien   = 1'b0;
        ack   = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
        seen_mask = 8'h00;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Reset with everything pending: quiet while in reset, request two edges after release.
        tifr = 8'hFF; timsk = 8'hFF; ien = 1'b1;
        tick();
        tick();
        chk("rst_req_low", 32'(irq_req), 0);
        chk("rst_mask_low", 32'(TIFR_clear_mask), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_req_edge1", 32'(irq_req), 0);
        tick();
        chk("rst_req_edge2", 32'(irq_req), 1);
        chk("rst_vec_ocf2", 32'(irq_vector), 'h008);

        // Single TOV1 interrupt, acked, flag cleared by the clear pulse.
        do_reset();
        timsk = 8'h04; ien = 1'b1;
        tick();
        tifr = 8'h04;
        tick();
        tick();
        chk("tov1_req", 32'(irq_req), 1);
        chk("tov1_vec", 32'(irq_vector), 'h012);
        ack = 1'b1;
        tick();
        chk("tov1_mask", 32'(TIFR_clear_mask), 'h04);
        tick();
        chk("tov1_mask_once", 32'(TIFR_clear_mask), 0);
        repeat (4) tick();
        chk("tov1_no_rereq", 32'(irq_req), 0);

        // Two flags: OCF1A served before TOV0, each with its own clear pulse.
        do_reset();
        p0 = pulse_cnt;
        tifr = 8'h11; timsk = 8'h11; ien = 1'b1;
        wait_req("two_req1");
        chk("two_vec1", 32'(irq_vector), 'h00E);
        ack = 1'b1;
        tick();
        chk("two_mask1", 32'(TIFR_clear_mask), 'h10);
        wait_req("two_req2");
        chk("two_vec2", 32'(irq_vector), 'h016);
        ack = 1'b1;
        tick();
        chk("two_mask2", 32'(TIFR_clear_mask), 'h01);
        repeat (4) tick();
        chk("two_pulses", 32'(pulse_cnt - p0), 2);
        chk("two_idle", 32'(irq_req), 0);

        // Masked flag: nothing pending until TIMSK enables it.
        do_reset();
        tifr = 8'h01; timsk = 8'h00; ien = 1'b1;
        repeat (3) tick();
        chk("mask_req0", 32'(irq_req), 0);
        chk("mask_pend0", 32'(irq_pending), 0);
        timsk = 8'h01;
        tick();
        tick();
        chk("mask_pend1", 32'(irq_pending), 1);
        chk("mask_req1", 32'(irq_req), 1);
        chk("mask_vec", 32'(irq_vector), 'h016);

        // I-bit withdrawal and re-presentation.
        do_reset();
        p0 = pulse_cnt;
        tifr = 8'h10; timsk = 8'h10; ien = 1'b1;
        wait_req("ibit_req");
        chk("ibit_vec", 32'(irq_vector), 'h00E);
        ien = 1'b0;
        tick();
        chk("ibit_withdraw", 32'(irq_req), 0);
        ien = 1'b1;
        tick();
        chk("ibit_rereq", 32'(irq_req), 1);
        chk("ibit_revec", 32'(irq_vector), 'h00E);
        chk("ibit_no_pulse", 32'(pulse_cnt - p0), 0);

        // Software clear withdraws; then three acknowledged interrupts.
        do_reset();
        p0 = pulse_cnt;
        tifr = 8'h04; timsk = 8'h04; ien = 1'b1;
        wait_req("sw_req");
        chk("sw_vec", 32'(irq_vector), 'h012);
        tifr = 8'h00;
        tick();
        tick();
        chk("sw_withdraw", 32'(irq_req), 0);
        chk("sw_no_pulse", 32'(pulse_cnt - p0), 0);
        for (int k = 0; k < 3; k++) begin
            tifr = 8'h04;
            wait_req("sw_ack_req");
            ack = 1'b1;
            repeat (4) tick();
        end
        chk("sw_three_pulses", 32'(pulse_cnt - p0), 3);
`ifdef TIMER_IRQ_COUNT_EN
        chk("sw_count3", 32'(irq_serviced_count), 3);
        chk("sw_last_vec", 32'(last_vector), 'h012);
`endif

        // Reset arriving together with an ack: no clear pulse.
        tifr = 8'h04;
        wait_req("rst_mid_req");
        p0 = pulse_cnt;
        ack = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 32'(irq_req), 0);
        tick();
        tick();
        chk("rst_mid_no_pulse", 32'(pulse_cnt - p0), 0);
        rst_n = 1'b1;
        tifr = 8'h00; timsk = 8'h00;
        tick();

        // Randomized traffic against the model.
        do_reset();
        ien = 1'b1;
        timsk = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 6 == 0)  tifr = tifr | 8'(1 << ($urandom % 8));
            if ($urandom % 20 == 0) tifr = tifr & ~8'(1 << ($urandom % 8));
            if ($urandom % 40 == 0) timsk = 8'($urandom);
            if ($urandom % 15 == 0) ien = ($urandom % 4 != 0);
            ack = irq_req ? ($urandom % 3 == 0) : ($urandom % 30 == 0);
            if ($urandom % 600 == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
